// File: rtl/scan_selector.sv
// Registered N-channel selector with manual select loading and a round-robin
// auto-scan mode that dwells a fixed number of cycles on each enabled channel.
module scan_selector #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int DWELL    = 8,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic                      load,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic [CHANNELS-1:0]       ch_en,
    input  logic [CHANNELS*WIDTH-1:0] din,
    output logic [WIDTH-1:0]          dout,
    output logic [SEL_W-1:0]          sel_out,
    output logic                      dout_valid,
    output logic                      wrap,
    output logic                      sel_err
);

    localparam int                 CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W:0]     CH_LIM   = (SEL_W + 1)'(CHANNELS);

    typedef enum logic [1:0] {
        ST_MANUAL = 2'd0,
        ST_SCAN   = 2'd1,
        ST_IDLE   = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [SEL_W-1:0]   sel_r, sel_s, next_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               wrap_s, err_s, adv_wrap_s;
    logic [WIDTH-1:0]   dout_s;
    logic               valid_s;

    // First enabled channel strictly above cur, searching round to the bottom.
    function automatic logic [SEL_W-1:0] next_en(input logic [SEL_W-1:0] cur,
                                                 input logic [CHANNELS-1:0] mask);
        logic [SEL_W-1:0] res;
        logic             found;
        res   = cur;
        found = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!found && mask[i] && (i > int'(cur))) begin
                res   = SEL_W'(i);
                found = 1'b1;
            end
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (!found && mask[i] && (i <= int'(cur))) begin
                res   = SEL_W'(i);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic en_at(input logic [SEL_W-1:0] s, input logic [CHANNELS-1:0] mask);
        logic res;
        res = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (SEL_W'(i) == s) begin
                res = mask[i];
            end
        end
        return res;
    endfunction

    function automatic logic [WIDTH-1:0] ch_at(input logic [SEL_W-1:0] s,
                                               input logic [CHANNELS*WIDTH-1:0] d);
        logic [WIDTH-1:0] res;
        res = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (SEL_W'(i) == s) begin
                res = d[i*WIDTH +: WIDTH];
            end
        end
        return res;
    endfunction

    // State, select and dwell counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_MANUAL;
            sel_r   <= '0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            sel_r   <= sel_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next state; a mode change outranks both load and dwell expiry.
    always_comb begin
        next_s     = next_en(sel_r, ch_en);
        adv_wrap_s = (next_s <= sel_r);
        state_s    = state_r;
        sel_s      = sel_r;
        cnt_s      = cnt_r;
        wrap_s     = 1'b0;
        err_s      = 1'b0;
        if (!mode) begin
            state_s = ST_MANUAL;
            cnt_s   = '0;
            if ((state_r == ST_MANUAL) && load) begin
                if ({1'b0, sel_in} < CH_LIM) begin
                    sel_s = sel_in;
                end else begin
                    err_s = 1'b1;
                end
            end else begin
                sel_s = sel_r;
            end
        end else if (ch_en == '0) begin
            state_s = ST_IDLE;
            cnt_s   = '0;
        end else begin
            state_s = ST_SCAN;
            case (state_r)
                ST_MANUAL: begin
                    cnt_s = '0;
                    if (!en_at(sel_r, ch_en)) begin
                        sel_s  = next_s;
                        wrap_s = adv_wrap_s;
                    end else begin
                        sel_s = sel_r;
                    end
                end
                ST_IDLE: begin
                    cnt_s  = '0;
                    sel_s  = next_s;
                    wrap_s = adv_wrap_s;
                end
                ST_SCAN: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_s  = '0;
                        sel_s  = next_s;
                        wrap_s = adv_wrap_s;
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_s = ST_MANUAL;
                    cnt_s   = '0;
                end
            endcase
        end
    end

    // Output values; dout follows the select held before the edge.
    always_comb begin
        dout_s  = ch_at(sel_r, din);
        valid_s = (state_s != ST_IDLE) && en_at(sel_s, ch_en);
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            sel_out    <= '0;
            dout_valid <= 1'b0;
            wrap       <= 1'b0;
            sel_err    <= 1'b0;
        end else begin
            dout       <= dout_s;
            sel_out    <= sel_s;
            dout_valid <= valid_s;
            wrap       <= wrap_s;
            sel_err    <= err_s;
        end
    end

endmodule

// File: doc/scan_selector.md
Name: scan_selector

Overview:
Parametrised N-channel, W-bit registered channel selector. It is the successor of the team's 4:1 combinational 4-bit selector.
- Adds a manual mode, where software loads the select.
- Adds an auto-scan mode, which steps round-robin through the enabled channels with a programmable dwell time.
- Intended use: time-multiplexed display/probe paths driven from the timing-control logic.

Parameters:
WIDTH, 4, data bits per channel
CHANNELS, 4, number of input channels (2..16)
DWELL, 8, cycles each channel is held in auto-scan (>=1)
SEL_W, 2, select width; must satisfy 2**SEL_W >= CHANNELS

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
mode  in  1  0 = manual, 1 = auto-scan; sampled every cycle
load  in  1  manual mode: capture sel_in this cycle
sel_in  in  SEL_W  requested channel for manual load
ch_en  in  CHANNELS  per-channel enable mask; bit i enables channel i
din  in  CHANNELS*WIDTH  packed inputs; channel i = din[i*WIDTH +: WIDTH]
dout  out  WIDTH  registered data of the current channel
sel_out  out  SEL_W  registered current channel index
dout_valid  out  1  current channel is enabled and not in IDLE
wrap  out  1  one-cycle pulse when auto-scan advances to a lower index
sel_err  out  1  one-cycle pulse on a rejected manual load

Behaviour:
- Reset (async assert, sync release):
  - state = MANUAL, sel = 0, dwell counter = 0
  - dout = 0, sel_out = 0, dout_valid = 0, wrap = 0, sel_err = 0
- Datapath:
  - dout <= din[sel] every cycle, where sel is the select register value before this edge.
  - Latency: din to dout is 1 cycle.
  - A change of sel appears on dout 1 cycle after sel_out changes.
- States: MANUAL, SCAN, IDLE.
- MANUAL (mode = 0):
  - load = 1 and sel_in < CHANNELS -> sel <= sel_in.
  - load = 1 and sel_in >= CHANNELS -> sel unchanged, sel_err = 1 for one cycle.
  - dout_valid = ch_en[sel], registered.
  - The dwell counter is held at 0.
- MANUAL -> SCAN when mode = 1:
  - Counter cleared; scanning starts from the current sel.
  - If ch_en[sel] = 0, advance to the next enabled channel on the first cycle.
- SCAN:
  - Counter increments every cycle.
  - At counter = DWELL-1: counter <= 0 and sel <= next enabled index above sel, searching modulo CHANNELS. Masked channels are skipped within a single cycle.
  - If the next enabled index is <= sel: wrap = 1 for that cycle.
  - If the only enabled channel is sel: sel unchanged and wrap = 1 each dwell period.
  - load and sel_in are ignored; sel_err is never raised.
- Any state -> IDLE when ch_en == 0 and mode = 1:
  - dout_valid = 0, sel held, counter held at 0.
  - dout keeps tracking din[sel].
- IDLE -> SCAN when ch_en != 0: advance to the next enabled channel above sel, with the counter cleared.
- SCAN or IDLE -> MANUAL when mode = 0: sel is held and the counter is cleared.
- Simultaneous events: a mode change takes priority over load and over dwell expiry in the same cycle.
- ch_en changing mid-dwell:
  - Takes effect at the next advance.
  - dout_valid follows ch_en[sel] immediately, with 1-cycle register latency.
- CHANNELS not a power of two: indices >= CHANNELS are never selected.
- Reset mid-scan: returns to the reset values above immediately. Scanning restarts only after mode is sampled as 1.

Test Plan:
- Reset/manual load:
  - Stimulus: rst_n low then high, din = {4'hD,4'hC,4'hB,4'hA}, ch_en = 4'b1111; load sel_in = 2.
  - Required: sel_out = 2 on the next edge; dout = 4'hC one cycle later; dout_valid = 1.
- Illegal select (CHANNELS = 3, SEL_W = 2):
  - Stimulus: load sel_in = 3.
  - Required: sel_err pulses one cycle, sel_out unchanged.
- Auto-scan, DWELL = 8, ch_en = 4'b1111:
  - Required: sel_out steps 0,1,2,3,0 every 8 cycles; wrap pulses exactly on the 3->0 step.
- Masked scan, ch_en = 4'b1010:
  - Required: sel_out alternates 1,3,1 with no visit to 0 or 2; wrap on each 3->1 step.
- Empty mask:
  - Stimulus: ch_en = 0 while scanning.
  - Required: dout_valid = 0 and sel_out frozen.
  - Then set ch_en = 4'b0100: sel_out = 2 next cycle; dwell restarts at 0.
- Async reset mid-dwell:
  - Stimulus: assert rst_n low between clock edges during scan.
  - Required: all outputs go to 0 without a clock edge; state returns to MANUAL.
